counter_sched: RTL

Time-shares one `counter` instance among NUM_REQ requesters. Each granted requester gets one full count run from COUNT_FROM to COUNT_TO, and receives a one-cycle done pulse when the run ends. The block drives the counter's en/rst and watches its out bus. It sits between the requesting engines and a single counter, so several engines can reuse one timebase without a counter each.

---
 rtl/counter_sched_pkg.sv | 18 +
 rtl/counter_sched_rr_arbiter.sv | 32 +++
 rtl/counter_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter time-sharing scheduler.
package counter_sched_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] LOAD = 2'd1;
    localparam logic [STATE_W-1:0] RUN  = 2'd2;
    localparam logic [STATE_W-1:0] DONE = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  gnt
);

    logic [N-1:0]  eligible;
    logic [PW-1:0] idx;
    logic          found;

    assign eligible = req & ~mask;

    // Walk the requesters starting at ptr, wrapping at N.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && eligible[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Time-shares one external counter among NUM_REQ requesters, one full run per grant.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COUNT_FROM = 0,
    parameter int unsigned COUNT_TO   = 10,
    parameter int unsigned STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] cnt_out,
    output logic                  cnt_en,
    output logic                  cnt_rst,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    localparam bit CFG_BAD = (STEP == 0) || (COUNT_TO < COUNT_FROM) ||
                             (((COUNT_TO - COUNT_FROM) % ((STEP == 0) ? 1 : STEP)) != 0) ||
                             ((64'(COUNT_TO) >> DATA_WIDTH) != 64'd0) ||
                             (NUM_REQ < 2) || (NUM_REQ > 16);

    if (CFG_BAD) begin : g_bad_cfg
        $error("counter_sched: bad parameters, COUNT_TO unreachable or NUM_REQ out of range");
    end

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  grant_nxt, done_nxt, arb_gnt, arb_mask;
    logic [PW-1:0]       ptr, ptr_nxt, arb_ptr, owner_idx, owner_next;
    logic                match, owner_req;

    assign match     = (cnt_out == DATA_WIDTH'(COUNT_TO));
    assign owner_req = |(req & grant);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        owner_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner_idx = PW'(i);
        end
    end

    assign owner_next = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);

    // In DONE the finishing owner is masked and priority starts just past it.
    assign arb_ptr  = (state == ST_DONE) ? owner_next : ptr;
    assign arb_mask = (state == ST_DONE) ? grant : '0;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req  (req),
        .ptr  (arb_ptr),
        .mask (arb_mask),
        .gnt  (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            grant <= '0;
            done  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            done  <= done_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        done_nxt  = '0;
        ptr_nxt   = ptr;
        cnt_en    = 1'b0;
        cnt_rst   = ~rst;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_nxt = arb_gnt;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_rst = 1'b1;
                if (!owner_req) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = owner_next;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort beats match, match beats hold.
                if (!owner_req) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = owner_next;
                end else if (match) begin
                    state_nxt = ST_DONE;
                    done_nxt  = grant;
                end else begin
                    cnt_en = rst & ~hold;
                end
            end
            ST_DONE: begin
                ptr_nxt = owner_next;
                if (|arb_gnt) begin
                    grant_nxt = arb_gnt;
                    state_nxt = ST_LOAD;
                end else begin
                    grant_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule
